// File: rtl/mau_host_driver.sv
// mau_host_driver
// Host-side sequencer for the matrix algebra unit (MAU). It takes commands and
// load bytes from a user stream, then issues instructions to the MAU only
// while busy_flag is low. For a load it streams the buffered matrix into
// data_in. For a store it captures a matrix from data_out and presents it on
// the read stream. For an op it waits for the MAU to finish.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   cmd_valid/ready/kind/instr command stream (kind: 00 load, 01 store,
//                              10 op, 11 reserved)
//   wr_valid/ready/data        load byte stream, row-major, element 0 first
//   rd_valid/ready/data        store byte stream, row-major
//   host_instruction, data_in  to the MAU
//   data_out, busy_flag        from the MAU
//   done, err                  one-cycle completion pulse; err=1 means the
//                              reserved kind was rejected
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready high, waiting for a command
// FILL       | accepting N load bytes into the buffer
// WAIT_FREE  | holding the instruction until busy_flag is low
// ISSUE      | host_instruction = latched instruction (cycle T)
// STREAM     | data_in = buffer[k] for k = 0..N-1, one byte per cycle
// CAPTURE    | RD_LAT-1 cycles of read latency, then N samples of data_out
// DRAIN      | presenting the captured bytes on the read stream
// OP_WAIT    | guard time after issue, then waiting for busy_flag low
// DONE       | done pulse, err for a rejected reserved command
module mau_host_driver #(
   parameter int          MATRIX_DIM = 8,
   parameter int          RD_LAT     = 2,
   parameter int          BUSY_GUARD = 2,
   parameter logic [7:0]  IDLE_INSTR = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_kind,
   input  logic [7:0] cmd_instr,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic [7:0] host_instruction,
   output logic [7:0] data_in,
   input  logic [7:0] data_out,
   input  logic       busy_flag,
   output logic       done,
   output logic       err
);

   localparam int N       = MATRIX_DIM * MATRIX_DIM;
   localparam int AW      = (N > 1) ? $clog2(N) : 1;
   localparam int CW      = AW + 1;
   localparam int TMR_MAX = (RD_LAT > BUSY_GUARD) ? RD_LAT : BUSY_GUARD;
   localparam int TW      = $clog2(TMR_MAX + 1) + 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_FREE,
      S_ISSUE,
      S_STREAM,
      S_CAPTURE,
      S_DRAIN,
      S_OP_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      kind_q, kind_d;
   logic [7:0]      instr_q, instr_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            live_q, live_d;
   logic [7:0]      buf_q [N];
   logic [7:0]      buf_d [N];
   logic [AW-1:0]   idx;

   assign idx = cnt_q[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         kind_q  <= 2'b00;
         instr_q <= 8'h00;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         live_q  <= 1'b0;
         buf_q   <= '{default: 8'h00};
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         live_q  <= live_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      kind_d           = kind_q;
      instr_d          = instr_q;
      err_d            = err_q;
      cnt_d            = cnt_q;
      tmr_d            = tmr_q;
      // Holds cmd_ready low until the first clock edge after reset release.
      live_d           = 1'b1;
      buf_d            = buf_q;
      cmd_ready        = 1'b0;
      wr_ready         = 1'b0;
      rd_valid         = 1'b0;
      rd_data          = 8'h00;
      host_instruction = IDLE_INSTR;
      data_in          = 8'h00;
      done             = 1'b0;
      err              = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = live_q;
            if (cmd_valid && live_q) begin
               instr_d = cmd_instr;
               kind_d  = cmd_kind;
               cnt_d   = '0;
               err_d   = 1'b0;
               case (cmd_kind)
                  2'b00:   state_d = S_FILL;
                  2'b01:   state_d = S_WAIT_FREE;
                  2'b10:   state_d = S_WAIT_FREE;
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end

         S_FILL: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               buf_d[idx] = wr_data;
               cnt_d      = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_WAIT_FREE;
               end
            end
         end

         S_WAIT_FREE: begin
            if (!busy_flag) begin
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            host_instruction = instr_q;
            cnt_d            = '0;
            case (kind_q)
               2'b00: state_d = S_STREAM;
               2'b01: begin
                  // The first sample lands RD_LAT cycles after issue; one of
                  // those cycles is the entry into CAPTURE itself.
                  tmr_d   = TW'(RD_LAT - 1);
                  state_d = S_CAPTURE;
               end
               default: begin
                  tmr_d   = TW'(BUSY_GUARD);
                  state_d = S_OP_WAIT;
               end
            endcase
         end

         S_STREAM: begin
            data_in = buf_q[idx];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end

         S_CAPTURE: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else begin
               buf_d[idx] = data_out;
               cnt_d      = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            rd_valid = 1'b1;
            rd_data  = buf_q[idx];
            if (rd_ready) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
         end

         S_OP_WAIT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else if (!busy_flag) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            err     = err_q;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: doc/mau_host_driver.md
Name: mau_host_driver

Overview:
- Host-side sequencer for the matrix algebra unit: the other end of its byte-wide instruction/data interface.
- Accepts commands and matrix bytes from a user stream, then issues instructions to the MAU only while busy_flag is low.
- Streams a full buffered matrix into the MAU's data_in, or captures a full matrix from its data_out and presents it on a user read stream.
- Sits between the SoC/testbench host logic and the MAU top level.

Parameters:
- MATRIX_DIM, 8, matrix side length; N = MATRIX_DIM*MATRIX_DIM bytes per matrix.
- RD_LAT, 2, cycles from store-instruction cycle to the first valid data_out byte.
- BUSY_GUARD, 2, cycles ignored after an op issue before busy_flag is sampled.
- IDLE_INSTR, 8'h00, instruction value driven when nothing is issued.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver accepts a command (high only in IDLE).
- cmd_kind  in  2  00 load, 01 store, 10 op, 11 reserved.
- cmd_instr  in  8  instruction byte forwarded verbatim to the MAU.
- wr_valid  in  1  load byte offered.
- wr_ready  out  1  driver accepts a load byte.
- wr_data  in  8  load byte, row-major, element 0 first.
- rd_valid  out  1  store byte available.
- rd_ready  in  1  user accepts a store byte.
- rd_data  out  8  store byte, row-major.
- host_instruction  out  8  to MAU host_instruction.
- data_in  out  8  to MAU data_in.
- data_out  in  8  from MAU data_out.
- busy_flag  in  1  from MAU busy_flag.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  valid with done; 1 = reserved kind rejected.

Behaviour:
- Reset (asynchronous) values:
  - cmd_ready=0, wr_ready=0, rd_valid=0, done=0, err=0.
  - host_instruction=IDLE_INSTR, data_in=0, rd_data=0.
  - State=IDLE; counters cleared; buffer contents discarded.
  - cmd_ready rises in the first cycle after rst deasserts.
- Buffer: one N-byte register array shared by load and store; never used by both at once. Counter cnt is $clog2(N)+1 bits wide.
- Handshakes: a transfer occurs on the rising edge where valid and ready are both high. Once rd_valid is asserted, rd_data holds until it is accepted.
- IDLE: cmd_ready=1. On accept:
  - kind 00 -> FILL.
  - kind 01 -> WAIT_FREE(store).
  - kind 10 -> WAIT_FREE(op).
  - kind 11 -> DONE with err=1; the MAU is never touched.
  - The accepted instruction is latched.
- FILL: wr_ready=1. Store wr_data at buffer[cnt], cnt++. When byte N-1 is accepted, go to WAIT_FREE(load); wr_ready falls the next cycle.
- WAIT_FREE: when busy_flag==0, go to ISSUE.
- ISSUE: host_instruction = latched instruction for exactly one cycle (cycle T), then IDLE_INSTR. Next state by kind:
  - load -> STREAM.
  - store -> CAPTURE.
  - op -> OP_WAIT.
- STREAM: data_in = buffer[k] at cycle T+1+k for k = 0..N-1, with no gaps; data_in=0 afterwards; then DONE.
- CAPTURE: sample data_out at cycle T+RD_LAT+k into buffer[k] for k = 0..N-1; then DRAIN.
- DRAIN: rd_valid=1, rd_data=buffer[cnt]. Each accept does cnt++. After byte N-1 is accepted, rd_valid=0 and go to DONE.
- OP_WAIT: ignore busy_flag for BUSY_GUARD cycles after T, then wait for busy_flag==0; then DONE.
- DONE: done=1 for one cycle, err as set (0 for kinds 00/01/10), then IDLE.
- Boundaries:
  - cmd_valid outside IDLE is ignored.
  - wr_valid outside FILL is ignored; wr_ready=0 there.
  - A user stall during FILL or DRAIN never affects MAU timing, because the MAU side always runs at one byte per cycle.
  - busy_flag toggling during STREAM or CAPTURE is ignored.
  - cnt wraps to 0 at every state entry that uses it.
  - rst asserted mid-command aborts immediately: outputs return to reset values, and no done pulse is produced for the aborted command.

Test Plan:
- MATRIX_DIM=2, load, instr 8'h11, bytes 01,02,03,04, busy_flag=0 -> host_instruction=11 for one cycle T; data_in=01,02,03,04 at T+1..T+4; done at T+5, err=0.
- Same load with busy_flag=1 for 10 cycles after FILL -> no instruction until busy_flag falls; identical byte timing relative to T.
- Store instr 8'h22, MAU model drives data_out=A0,A1,A2,A3 from T+2, rd_ready toggling 1,0,1,0 -> rd_data sequence A0,A1,A2,A3 in order, with no loss or duplication; done after the last accept.
- Op instr 8'h33, busy_flag high T+1..T+20 -> done pulse at the cycle after busy_flag is first sampled low at or after T+3.
- cmd_kind=11 -> done=1 and err=1 in the cycle after accept; host_instruction stays 00 throughout.
- rst pulsed during STREAM after 2 bytes -> data_in=0 and host_instruction=00 immediately; cmd_ready=1 the cycle after release; no done pulse.
